ring_osc_freq_meter: RTL

Measures the frequency of a free-running ring-oscillator output against the system clock. It counts synchronized rising edges of `osc_in` over a programmable gate window of `clk` cycles and presents the count through a valid/ready result port. It sits on the receiving side of every oscillator instance, in the clocked domain, and gives digital readback of oscillator delay and frequency.

---
 rtl/ring_osc_pkg.sv | 14 +
 rtl/ring_osc_freq_meter_if.sv | 31 +++
 rtl/osc_edge_sync.sv | 28 ++
 rtl/ring_osc_freq_meter.sv | 100 ++++++++++
 4 files changed

// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared state type and default sizing for the ring-oscillator meter
package ring_osc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        HOLD = 2'd3
    } meter_state_e;

    localparam int DEFAULT_GATE_CYCLES = 1024;
    localparam int DEFAULT_CNT_W       = 16;

endpackage

// File: rtl/ring_osc_freq_meter_if.sv
// rtl/ring_osc_freq_meter_if.sv - start/busy control and valid/ready result port of the meter
interface ring_osc_freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [CNT_W-1:0] result_count;
    logic             overflow;

    // Consumer side: requests measurements and accepts results
    modport master (
        output start,
        output result_ready,
        input  busy,
        input  result_valid,
        input  result_count,
        input  overflow
    );

    // Meter side
    modport slave (
        input  start,
        input  result_ready,
        output busy,
        output result_valid,
        output result_count,
        output overflow
    );
endinterface

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - 3-flop synchronizer with rising-edge pulse for an asynchronous oscillator tap
module osc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    // sync_q[0]/[1] are the metastability stages, sync_q[2] is the delayed copy for edge detection
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw input one stage per clock
    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    // Synchronizer register chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - counts oscillator rising edges over a fixed gate window of clk cycles
module ring_osc_freq_meter
    import ring_osc_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 osc_in,
    ring_osc_freq_meter_if.slave meter
);
    localparam int             GW        = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);

    logic rise;

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] result_count_q, result_count_d;
    logic             overflow_q, overflow_d;

    osc_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (osc_in),
        .rise     (rise)
    );

    // Next-state, counter and result-register logic
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        gate_cnt_d     = gate_cnt_q;
        result_count_d = result_count_q;
        overflow_d     = overflow_q;

        case (state_q)
            IDLE: begin
                if (meter.start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                edge_cnt_d     = '0;
                gate_cnt_d     = '0;
                result_count_d = '0;
                overflow_d     = 1'b0;
                state_d        = GATE;
            end
            GATE: begin
                // Saturate rather than wrap so a too-fast oscillator never reads as slow
                if (rise) begin
                    if (&edge_cnt_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                gate_cnt_d = gate_cnt_q + GW'(1);
                if (gate_cnt_q == GATE_LAST) begin
                    result_count_d = edge_cnt_d;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                if (meter.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            edge_cnt_q     <= '0;
            gate_cnt_q     <= '0;
            result_count_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            gate_cnt_q     <= gate_cnt_d;
            result_count_q <= result_count_d;
            overflow_q     <= overflow_d;
        end
    end

    assign meter.busy         = (state_q == ARM) || (state_q == GATE);
    assign meter.result_valid = (state_q == HOLD);
    assign meter.result_count = result_count_q;
    assign meter.overflow     = overflow_q;

endmodule
